hilo_divider: RTL and testbench
===============================

# hilo_divider

Sequential 32-bit unsigned divider (DIVU, function code 27) for the TotalALU datapath. It is the division counterpart of the shift-add multiplier and uses the same Signal/dataA/dataB/Output interface and HI/LO convention. A started division runs a fixed 32-cycle restoring shift-subtract sequence, then writes the quotient to LO and the remainder to HI. MFHI (16) and MFLO (18) read those registers back through Output.

## Interface
- WIDTH, 32: operand and result width.
- SIG_DIVU, 6'd27: Signal code that starts a division.
- SIG_MFHI, 6'd16: Signal code that selects HI onto Output.
- SIG_MFLO, 6'd18: Signal code that selects LO onto Output.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; has priority over every other input.
- dataA  input  WIDTH  dividend; sampled only on the start edge.
- dataB  input  WIDTH  divisor; sampled only on the start edge.
- Signal  input  6  operation code from the ALU control.
- Output  output  WIDTH  combinational read mux. HI when Signal==SIG_MFHI, LO when Signal==SIG_MFLO, otherwise 0.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse in the cycle after HI/LO are written.

## Operation
- State machine has two states, IDLE and RUN.
- IDLE to RUN: taken on an edge where Signal==SIG_DIVU and state is IDLE. On that edge:
  - rem <= 0, quo <= dataA, div <= dataB, count <= 0.
- RUN step, one per edge, counting over 32 iterations:
  - trial = {rem, quo[WIDTH-1]} - {1'b0, div}, evaluated at 33-bit width.
  - If trial is non-negative: rem <= trial[31:0] and a 1 is shifted into quo's LSB.
  - Otherwise: rem <= {rem[30:0], quo[31]} and a 0 is shifted into quo's LSB.
  - In both cases quo shifts left by 1.
  - count increments.
- Final step (count==31):
  - LO <= final quotient and HI <= final remainder, written on the same edge.
  - Next state is IDLE, and done is set for one cycle.
- Divide by zero needs no special case. The algorithm naturally yields LO = 32'hFFFFFFFF and HI = dividend, and still takes 32 cycles.
- Signal==SIG_DIVU while in RUN is ignored. There is no queueing and no restart.
- HI/LO keep the previous result during RUN, so MFHI/MFLO during RUN return the old values.
- Signal values outside {27, 16, 18} have no effect on state, and Output is 0.
- All arithmetic is unsigned and there is no overflow condition.

## Timing
- Reset values: state=IDLE, HI=0, LO=0, rem=0, quo=0, div=0, count=0, busy=0, done=0. Output follows from these (0 for every Signal).
- Cycle numbering: the start edge is edge N.
  - busy=1 from just after edge N until edge N+32.
  - Iterations occur on edges N+1 through N+32.
  - HI/LO are valid from just after edge N+32.
  - done=1 between edges N+32 and N+33. busy=0 in that same cycle.
- Back-to-back starts: a new start is accepted at edge N+33, i.e. in the done cycle when Signal==27.
- Output is purely combinational from Signal and HI/LO. MFHI/MFLO values are therefore readable in the same cycle Signal changes, with no added latency.
- Reset asserted mid-operation, on any edge:
  - Aborts the operation, returns to IDLE, and clears HI/LO.
  - No done pulse is produced.
- Reset on the same edge as a start: reset wins and no division begins.

## Test plan
- 100 / 7:
  - Start at edge 1.
  - busy high for 32 cycles, done pulse at cycle 33.
  - MFLO -> 14, MFHI -> 2.
- 32'hFFFFFFFF / 1 -> LO=32'hFFFFFFFF, HI=0. Then 3 / 10 -> LO=0, HI=3, with the second start issued in the done cycle of the first.
- Divide by zero: 5 / 0 -> after 32 cycles LO=32'hFFFFFFFF, HI=5, and done pulses normally.
- Ignored start and stale reads:
  - Complete 100/7.
  - Start 50/5, then reassert Signal=27 with 9/3 at cycle 5 of the run.
  - The second start is ignored.
  - MFHI at cycle 10 -> 2 (stale).
  - Final result LO=10, HI=0.
- Reset mid-run:
  - Start 1000/3 and assert reset at cycle 10.
  - busy=0, HI=LO=0, no done pulse.
  - A fresh 1000/3 afterwards -> LO=333, HI=1.
- Output mux: with HI=2 and LO=14, Signal=36 -> Output=0, Signal=16 -> 2, Signal=18 -> 14, each in the same cycle.

Source files
------------

// File: rtl/hilo_divider.sv
// hilo_divider: sequential 32-bit unsigned restoring divider (DIVU).
// One quotient bit per clock: 32 iterations after the start edge, after which
// LO holds the quotient and HI the remainder. MFHI/MFLO read them back through
// a combinational output mux.
module hilo_divider #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] SIG_DIVU = 6'd27,
  parameter logic [5:0] SIG_MFHI = 6'd16,
  parameter logic [5:0] SIG_MFLO = 6'd18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d, quo_d;

  // One restoring step: subtract when the shifted partial remainder covers the divisor.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM and datapath registers; reset aborts any run and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Signal == SIG_DIVU) begin
            state_q <= RUN;
            rem_q   <= '0;
            quo_q   <= dataA;
            div_q   <= dataB;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // Starts arriving here are dropped: no queueing, no restart.
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            lo_q    <= quo_d;
            hi_q    <= rem_d;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read mux: zero-latency HI/LO readback, zero for any other code.
  always_comb begin
    Output = '0;
    if (Signal == SIG_MFHI)      Output = hi_q;
    else if (Signal == SIG_MFLO) Output = lo_q;
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: starts push expected {LO,HI} from plain
// integer division; read-backs push observed values; a monitor pairs them.
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB, Output;
  logic [5:0]  Signal;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  hilo_divider dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .Output(Output), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: quotient/remainder by definition; x/0 gives all-ones, remainder x.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  // Monitor: pair each observed read-back with the oldest expected result.
  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      logic [63:0] o, e;
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_result: got %h expected none", o);
      end else begin
        e = exp_q.pop_front();
        chk("LO", o[63:32], e[63:32]);
        chk("HI", o[31:0], e[31:0]);
      end
    end
  end

  // Issue a start in the current cycle; returns just after the start edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    Signal = 6'd27; dataA = a; dataB = b;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    Signal = 6'd0; dataA = $urandom; dataB = $urandom;
  endtask

  // Called just after the start edge. Checks busy for 32 cycles, done on the
  // 33rd, then reads LO/HI in the done cycle and hands them to the monitor.
  task automatic run_check(input bit ign, input bit stale, input logic [31:0] stale_hi);
    logic [31:0] lo, hi;
    for (int i = 0; i < 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) begin
        chk("busy_during_run", {30'd0, busy, done}, 32'd2);
      end
      if (ign && i == 5) begin Signal = 6'd27; dataA = 32'd9; dataB = 32'd3; end
      if (ign && i == 6) Signal = 6'd0;
      if (stale && i == 10) begin
        Signal = 6'd16; #1;
        chk("stale_MFHI", Output, stale_hi);
        Signal = 6'd0;
      end
      @(posedge clk); #1;
    end
    chk("done_pulse", {30'd0, busy, done}, 32'd1);
    Signal = 6'd18; #1; lo = Output;
    Signal = 6'd16; #1; hi = Output;
    Signal = 6'd0;
    obs_q.push_back({lo, hi});
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b1; Signal = 6'd0; dataA = '0; dataB = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    Signal = 6'd16; #1; chk("rst_MFHI", Output, 32'd0);
    Signal = 6'd18; #1; chk("rst_MFLO", Output, 32'd0);

    // Reset wins over a simultaneous start
    Signal = 6'd27; dataA = 32'd8; dataB = 32'd2;
    @(posedge clk); #1;
    reset = 1'b0; Signal = 6'd0;
    chk("rst_vs_start_busy", {31'd0, busy}, 32'd0);

    // 100 / 7
    do_start(32'd100, 32'd7);
    run_check(1'b0, 1'b0, 32'd0);

    // Output mux, same-cycle readback
    Signal = 6'd36; #1; chk("mux_other", Output, 32'd0);
    Signal = 6'd16; #1; chk("mux_MFHI", Output, 32'd2);
    Signal = 6'd18; #1; chk("mux_MFLO", Output, 32'd14);
    Signal = 6'd0;

    // FFFFFFFF/1 then 3/10 started in the done cycle
    do_start(32'hFFFF_FFFF, 32'd1);
    run_check(1'b0, 1'b0, 32'd0);
    do_start(32'd3, 32'd10);
    run_check(1'b0, 1'b0, 32'd0);

    // Divide by zero
    do_start(32'd5, 32'd0);
    run_check(1'b0, 1'b0, 32'd0);

    // Ignored start mid-run and stale HI read
    do_start(32'd100, 32'd7);
    run_check(1'b0, 1'b0, 32'd0);
    do_start(32'd50, 32'd5);
    run_check(1'b1, 1'b1, 32'd2);

    // Reset mid-run: abort, clear HI/LO, no done pulse
    @(posedge clk); #1;
    do_start(32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    Signal = 6'd16; #1; chk("abort_HI", Output, 32'd0);
    Signal = 6'd18; #1; chk("abort_LO", Output, 32'd0);
    Signal = 6'd0;
    begin
      int seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done) seen++; end
      chk("abort_no_done", seen, 0);
    end
    do_start(32'd1000, 32'd3);
    run_check(1'b0, 1'b0, 32'd0);

    // Randomized back-to-back divisions
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = (k % 6 == 0) ? 32'd0 : a >> $urandom_range(0, 31);
        default: b = a;
      endcase
      do_start(a, b);
      run_check(1'b0, 1'b0, 32'd0);
    end

    @(posedge clk); @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size() + obs_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
